// File: rtl/somador_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package somador_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SOMANDO = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  localparam int N_PADRAO = 8;

endpackage

// File: rtl/somador_serial_somador1Bit.sv
// 1-bit full adder cell reused by the serial adder datapath.
module somador1Bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, result valid N+1 cycles after start.
//
// state   | meaning
// OCIOSO  | idle, waiting for start
// SOMANDO | adding one bit per cycle (busy)
// PRONTO  | result new this cycle (done); start accepted back-to-back
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] soma,
  output logic         cout
);

  localparam int CW = $clog2(N);

  estado_t         estado_q, estado_d;
  logic [N-1:0]    reg_a_q, reg_a_d;
  logic [N-1:0]    reg_b_q, reg_b_d;
  logic [N-1:0]    reg_s_q, reg_s_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cont_q, cont_d;
  logic [N-1:0]    soma_q, soma_d;
  logic            cout_q, cout_d;
  logic            s_fa, cout_fa;
  logic            aceita;

  somador1Bit u_fa (
    .A    (reg_a_q[0]),
    .B    (reg_b_q[0]),
    .Cin  (carry_q),
    .S    (s_fa),
    .Cout (cout_fa)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      reg_s_q  <= '0;
      carry_q  <= 1'b0;
      cont_q   <= '0;
      soma_q   <= '0;
      cout_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      reg_s_q  <= reg_s_d;
      carry_q  <= carry_d;
      cont_q   <= cont_d;
      soma_q   <= soma_d;
      cout_q   <= cout_d;
    end
  end

  // start is only honoured outside SOMANDO; there is no request queue.
  assign aceita = start && (estado_q != SOMANDO);

  always_comb begin
    estado_d = estado_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    reg_s_d  = reg_s_q;
    carry_d  = carry_q;
    cont_d   = cont_q;
    soma_d   = soma_q;
    cout_d   = cout_q;
    case (estado_q)
      OCIOSO, PRONTO: begin
        estado_d = aceita ? SOMANDO : OCIOSO;
        if (aceita) begin
          reg_a_d = a;
          reg_b_d = b;
          carry_d = cin;
          cont_d  = '0;
        end
      end
      SOMANDO: begin
        reg_s_d = {s_fa, reg_s_q[N-1:1]};
        reg_a_d = reg_a_q >> 1;
        reg_b_d = reg_b_q >> 1;
        carry_d = cout_fa;
        cont_d  = cont_q + CW'(1);
        if (cont_q == CW'(N - 1)) begin
          estado_d = PRONTO;
          soma_d   = {s_fa, reg_s_q[N-1:1]};
          cout_d   = cout_fa;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign busy = (estado_q == SOMANDO);
  assign done = (estado_q == PRONTO);
  assign soma = soma_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: vector table + scoreboard on N=8, random sums on N=5.
module tb_somador_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] soma8;
  logic       start5 = 1'b0, cin5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       busy5, done5, cout5;
  logic [4:0] soma5;

  int n_vec  = 0;
  int n_fail = 0;

  logic [8:0] q8[$];
  logic [8:0] ultimo8 = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] soma;
    logic       cout;
  } vec_t;

  vec_t tabela[7];

  always #5 clk = ~clk;

  somador_serial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .soma(soma8), .cout(cout8)
  );

  somador_serial #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .cin(cin5),
    .busy(busy5), .done(done5), .soma(soma5), .cout(cout5)
  );

  task automatic verifica(input string nome, input logic [31:0] real_v, input logic [31:0] esperado);
    n_vec++;
    if (real_v !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, real_v, esperado);
    end
  endtask

  // Scoreboard monitor for the N=8 instance.
  always @(posedge clk) begin
    logic r;
    logic [8:0] exp_v;
    r = rst;
    #1;
    if (r) begin
      verifica("reset_out8", {busy8, done8, cout8, soma8}, 32'h0);
      ultimo8 = '0;
      q8.delete();
    end else if (done8) begin
      if (q8.size() == 0) begin
        verifica("unexpected_done8", 32'd1, 32'd0);
      end else begin
        exp_v = q8.pop_front();
        verifica("soma8", {cout8, soma8}, exp_v);
      end
      ultimo8 = {cout8, soma8};
    end else begin
      verifica("hold8", {cout8, soma8}, ultimo8);
    end
  end

  // Drives one start on the N=8 instance and waits for done; returns cycles to done.
  task automatic soma8_uma(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                           input logic [8:0] esperado, output int k);
    @(negedge clk);
    start8 = 1'b1; a8 = va; b8 = vb; cin8 = vc;
    q8.push_back(esperado);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) start8 = 1'b0;
      if (done8) break;
      if (!busy8) verifica("busy8_during_sum", 32'd0, 32'd1);
    end
    if (!done8) verifica("timeout8", 32'd0, 32'd1);
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    logic [8:0] exp_v;
    logic [5:0] exp5;
    logic [5:0] prev5;

    tabela[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tabela[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tabela[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tabela[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tabela[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tabela[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tabela[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    espera(3);
    rst = 1'b0;
    espera(2);

    for (int i = 0; i < 7; i++) begin
      soma8_uma(tabela[i].a, tabela[i].b, tabela[i].cin, {tabela[i].cout, tabela[i].soma}, k);
      verifica("latency8", k, 9);
      espera(2);
    end

    // Back-to-back via separate starts issued right in PRONTO.
    soma8_uma(8'h01, 8'h02, 1'b0, 9'h003, k);
    soma8_uma(8'hF0, 8'h20, 1'b1, 9'h111, k);
    verifica("latency8_b2b", k, 9);

    // Starts during SOMANDO with other operands are ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h12; cin8 = 1'b0;
    q8.push_back(9'h033);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 2 || k == 4) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
      else start8 = 1'b0;
      if (done8) break;
    end
    if (!done8) verifica("timeout8_ign", 32'd0, 32'd1);
    verifica("latency8_ign", k, 9);
    espera(12);

    // Reset mid-operation discards the sum.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    q8.push_back(9'h077);
    repeat (4) @(negedge clk);
    start8 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    espera(15);
    verifica("no_done_after_rst", q8.size(), 0);

    // start held high: a sum every 9 cycles.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    q8.push_back(9'h100);
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (k < 20) begin
        @(posedge clk); #1;
        k++;
        if (done8) break;
      end
      if (!done8) verifica("timeout8_hold", 32'd0, 32'd1);
      verifica("period8_hold", k, 9);
      if (i < 2) q8.push_back(9'h100);
      else start8 = 1'b0;
    end
    espera(12);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp_v = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      soma8_uma(ra, rb, rc, exp_v, k);
      if (($urandom & 3) == 0) espera(2);
    end
    espera(3);
    verifica("q8_empty", q8.size(), 0);

    // Random sums on the N=5 instance, checking latency and output hold.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start5 = 1'b1; a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
      exp5 = {1'b0, a5} + {1'b0, b5} + {5'h00, cin5};
      prev5 = {cout5, soma5};
      k = 0;
      while (k < 20) begin
        @(posedge clk); #1;
        k++;
        if (k == 1) start5 = 1'b0;
        if (done5) break;
        if ({cout5, soma5} !== prev5) verifica("hold5", {cout5, soma5}, prev5);
      end
      if (!done5) verifica("timeout5", 32'd0, 32'd1);
      verifica("latency5", k, 6);
      verifica("soma5", {cout5, soma5}, exp5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
